ctr_loader: RTL and testbench
=============================

CTR_LOADER -- requirements
Module: ctr_loader

Interface
REQ-001 Parameter OFS1, default 30: expected read offset for Offset code 2'b01.
REQ-002 Parameter OFS2, default 60: expected read offset for Offset code 2'b10.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  one clock; reset is asynchronous and active-low (Reset=0 resets).
REQ-005 ReqValid  input  1  request present.
REQ-006 ReqReady  output  1  loader accepts request this cycle.
REQ-007 ReqWrite  input  1  1 = write-then-read; 0 = read-only.
REQ-008 ReqVal  input  8  value to load into counter.
REQ-009 ReqOffset  input  2  offset code for readback.
REQ-010 WriteEn  output  1  counter write strobe.
REQ-011 ValIn  output  8  counter write data.
REQ-012 Offset  output  2  counter read-offset select.
REQ-013 CtrValOut  input  8  counter combinational read value.
REQ-014 RspValid  output  1  response present.
REQ-015 RspReady  input  1  consumer accepts response.
REQ-016 RspData  output  8  captured counter readback.
REQ-017 RspErr  output  1  readback mismatch flag (write requests only).
REQ-018 ErrCount  output  8  saturating count of mismatches.

Function
REQ-019 FSM states IDLE, WRITE, READ, RESP; one-hot or binary encoding permitted.
REQ-020 IDLE: ReqReady=1; on ReqValid&&ReqReady latch ReqWrite/ReqVal/ReqOffset; go to WRITE if ReqWrite=1, else READ.
REQ-021 WRITE (exactly one cycle): WriteEn=1, ValIn=latched ReqVal, Offset=2'b00; then READ.
REQ-022 READ (exactly one cycle): WriteEn=0, Offset=latched ReqOffset; capture CtrValOut into RspData at cycle end; then RESP.
REQ-023 RESP: RspValid=1, RspData/RspErr stable; on RspReady go to IDLE; else hold.
REQ-024 Outside WRITE: WriteEn=0, ValIn=8'h00; outside READ: Offset=2'b00.
REQ-025 ReqReady=0 in WRITE, READ, RESP; no request accepted while busy; back-to-back acceptance allowed on the cycle after RESP handshake.
REQ-026 Latency, write request: accept edge N, WriteEn high cycle N+1, Offset driven cycle N+2, RspValid high from cycle N+3.
REQ-027 Latency, read-only request: RspValid high from cycle N+2.
REQ-028 Expected value = (ReqVal + add) mod 256; add = 0, OFS1, OFS2, 0 for codes 00, 01, 10, 11; 8-bit wrap-around, no saturation.
REQ-029 RspErr = (captured != expected) for write requests; RspErr=0 for read-only requests.
REQ-030 ErrCount increments by 1 on the READ→RESP transition when RspErr is set; holds at 8'hFF.

Reset
REQ-031 Reset=0 forces IDLE asynchronously, regardless of state, including mid-transaction.
REQ-032 Reset values: ReqReady=1 (after reset released), WriteEn=0, ValIn=0, Offset=0, RspValid=0, RspData=0, RspErr=0, ErrCount=0, latched request fields=0.
REQ-033 A transaction interrupted by reset is discarded; no response is produced.

Structure
REQ-034 Shared package holds the FSM state enum, OFS1/OFS2 defaults, and the offset-code constants (00, 01, 10, 11).
REQ-035 No sub-module; the counter being driven is instantiated only in the testbench/top level, not inside ctr_loader.

Verification
REQ-036 Write ReqVal=8'd5, ReqOffset=2'b01 to a correct counter -> WriteEn pulse with ValIn=5 at N+1, RspData=35, RspErr=0 at N+3.
REQ-037 Write ReqVal=8'd250, ReqOffset=2'b10 -> RspData=8'd54 (wrap), RspErr=0.
REQ-038 Read-only ReqOffset=2'b11 after loading 8'd17 -> no WriteEn, RspData=17 at N+2, RspErr=0.
REQ-039 Counter model forced to ignore writes (holds 0), write ReqVal=8'd9, ReqOffset=2'b00 -> RspErr=1, ErrCount 0->1; 300 such requests -> ErrCount=8'hFF.
REQ-040 RspReady held low 10 cycles -> RspValid/RspData stable, ReqReady=0, new ReqValid ignored until handshake.
REQ-041 Reset asserted during READ -> IDLE immediately, RspValid never asserts, WriteEn=0, ErrCount=0.

Source files
------------

// File: rtl/ctr_loader_pkg.sv
// Shared types and constants for the counter loader: FSM states, default
// readback offsets and the offset-code encodings.
package ctr_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int unsigned OFS1_DEF = 30;
    localparam int unsigned OFS2_DEF = 60;

    localparam logic [1:0] OFS_CODE_0 = 2'b00;
    localparam logic [1:0] OFS_CODE_1 = 2'b01;
    localparam logic [1:0] OFS_CODE_2 = 2'b10;
    localparam logic [1:0] OFS_CODE_3 = 2'b11;

    // Amount the counter adds to its readback for a given offset code.
    function automatic logic [7:0] offset_add(input logic [1:0] code,
                                              input logic [7:0] ofs1,
                                              input logic [7:0] ofs2);
        case (code)
            OFS_CODE_1: return ofs1;
            OFS_CODE_2: return ofs2;
            default:    return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/ctr_loader.sv
// Loads a value into an external counter, reads it back through an offset
// select, and reports the readback with a mismatch flag and error count.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; latch it on ReqValid
// ST_WRITE | one-cycle WriteEn pulse carrying the latched value
// ST_READ  | one cycle driving the read offset; capture CtrValOut at end
// ST_RESP  | hold response until RspReady
module ctr_loader
    import ctr_loader_pkg::*;
#(
    parameter int unsigned OFS1 = OFS1_DEF,
    parameter int unsigned OFS2 = OFS2_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ReqValid,
    output logic       ReqReady,
    input  logic       ReqWrite,
    input  logic [7:0] ReqVal,
    input  logic [1:0] ReqOffset,
    output logic       WriteEn,
    output logic [7:0] ValIn,
    output logic [1:0] Offset,
    input  logic [7:0] CtrValOut,
    output logic       RspValid,
    input  logic       RspReady,
    output logic [7:0] RspData,
    output logic       RspErr,
    output logic [7:0] ErrCount
);

    state_t     state;
    logic       lat_write;
    logic [7:0] lat_val;
    logic [1:0] lat_ofs;
    logic [7:0] expected;
    logic       mismatch;

    assign expected = lat_val + offset_add(lat_ofs, 8'(OFS1), 8'(OFS2));
    // Read-only requests have no reference value, so they never flag.
    assign mismatch = lat_write && (CtrValOut != expected);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            lat_write <= 1'b0;
            lat_val   <= 8'h00;
            lat_ofs   <= 2'b00;
            ReqReady  <= 1'b1;
            WriteEn   <= 1'b0;
            ValIn     <= 8'h00;
            Offset    <= OFS_CODE_0;
            RspValid  <= 1'b0;
            RspData   <= 8'h00;
            RspErr    <= 1'b0;
            ErrCount  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ReqValid && ReqReady) begin
                        lat_write <= ReqWrite;
                        lat_val   <= ReqVal;
                        lat_ofs   <= ReqOffset;
                        ReqReady  <= 1'b0;
                        if (ReqWrite) begin
                            state   <= ST_WRITE;
                            WriteEn <= 1'b1;
                            ValIn   <= ReqVal;
                        end else begin
                            state  <= ST_READ;
                            Offset <= ReqOffset;
                        end
                    end
                end
                ST_WRITE: begin
                    WriteEn <= 1'b0;
                    ValIn   <= 8'h00;
                    Offset  <= lat_ofs;
                    state   <= ST_READ;
                end
                ST_READ: begin
                    Offset   <= OFS_CODE_0;
                    RspData  <= CtrValOut;
                    RspErr   <= mismatch;
                    RspValid <= 1'b1;
                    if (mismatch && (ErrCount != 8'hFF))
                        ErrCount <= ErrCount + 8'd1;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        ReqReady <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ReqReady <= 1'b1;
                    WriteEn  <= 1'b0;
                    ValIn    <= 8'h00;
                    Offset   <= OFS_CODE_0;
                    RspValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_loader.sv
// Scoreboard bench for ctr_loader driving a behavioural counter with a
// fault mode that makes the counter ignore writes.
module tb_ctr_loader;

    logic       Clk;
    logic       Reset;
    logic       ReqValid;
    logic       ReqReady;
    logic       ReqWrite;
    logic [7:0] ReqVal;
    logic [1:0] ReqOffset;
    logic       WriteEn;
    logic [7:0] ValIn;
    logic [1:0] Offset;
    logic [7:0] CtrValOut;
    logic       RspValid;
    logic       RspReady;
    logic [7:0] RspData;
    logic       RspErr;
    logic [7:0] ErrCount;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    ctr_loader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqVal    (ReqVal),
        .ReqOffset (ReqOffset),
        .WriteEn   (WriteEn),
        .ValIn     (ValIn),
        .Offset    (Offset),
        .CtrValOut (CtrValOut),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspData   (RspData),
        .RspErr    (RspErr),
        .ErrCount  (ErrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Counter under control; stuck mode holds it at zero and drops writes.
    logic [7:0] cnt;
    logic       stuck;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset)         cnt <= 8'h00;
        else if (stuck)     cnt <= 8'h00;
        else if (WriteEn)   cnt <= ValIn;
    end

    always_comb begin
        CtrValOut = cnt;
        case (Offset)
            2'b01:   CtrValOut = cnt + 8'd30;
            2'b10:   CtrValOut = cnt + 8'd60;
            default: CtrValOut = cnt;
        endcase
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: consume a response on each handshake and compare to the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset && RspValid && RspReady) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got data %0d want no response", RspData);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", RspData, e.data);
                    chk("rsp_err", 8'(RspErr), 8'(e.err));
                    chk("err_count", ErrCount, e.cnt);
                end
            end
        end
    end

    // Present a request and return just after its accepting edge.
    task automatic issue(input logic w, input logic [7:0] v, input logic [1:0] o,
                         input logic push, input logic [7:0] ed, input logic ee,
                         input logic [7:0] ec);
        int n = 0;
        if (push) exp_q.push_back('{data: ed, err: ee, cnt: ec});
        ReqValid  = 1'b1;
        ReqWrite  = w;
        ReqVal    = v;
        ReqOffset = o;
        @(negedge Clk);
        while (!ReqReady && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("accept_ready", 8'(ReqReady), 8'd1);
        @(posedge Clk);
        #1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqVal    = 8'h00;
        ReqOffset = 2'b00;
    endtask

    task automatic check_lat(input logic w, input logic [7:0] v, input logic [1:0] o);
        @(negedge Clk);
        chk("wren_n1", 8'(WriteEn), 8'(w));
        chk("valin_n1", ValIn, w ? v : 8'h00);
        if (w) begin
            chk("ofs_n1", 8'(Offset), 8'd0);
            @(negedge Clk);
            chk("wren_n2", 8'(WriteEn), 8'd0);
            chk("ofs_n2", 8'(Offset), 8'(o));
            chk("rspv_n2", 8'(RspValid), 8'd0);
        end else begin
            chk("ofs_n1", 8'(Offset), 8'(o));
            chk("rspv_n1", 8'(RspValid), 8'd0);
        end
        @(negedge Clk);
        chk("rspv_lat", 8'(RspValid), 8'd1);
        chk("ofs_resp", 8'(Offset), 8'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (!ReqReady && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_return", 8'(ReqReady), 8'd1);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset     = 1'b0;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqVal    = 8'h00;
        ReqOffset = 2'b00;
        RspReady  = 1'b1;
        stuck     = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_reqready", 8'(ReqReady), 8'd1);
        chk("rst_wren", 8'(WriteEn), 8'd0);
        chk("rst_valin", ValIn, 8'd0);
        chk("rst_offset", 8'(Offset), 8'd0);
        chk("rst_rspvalid", 8'(RspValid), 8'd0);
        chk("rst_rspdata", RspData, 8'd0);
        chk("rst_rsperr", 8'(RspErr), 8'd0);
        chk("rst_errcount", ErrCount, 8'd0);
        @(posedge Clk);
        #1;

        // Write 5 with offset code 01: 5 + 30 = 35
        issue(1'b1, 8'd5, 2'b01, 1'b1, 8'd35, 1'b0, 8'd0);
        check_lat(1'b1, 8'd5, 2'b01);
        wait_idle();

        // Write 250 with code 10: (250 + 60) mod 256 = 54
        issue(1'b1, 8'd250, 2'b10, 1'b1, 8'd54, 1'b0, 8'd0);
        check_lat(1'b1, 8'd250, 2'b10);
        wait_idle();

        // Load 17 with code 11 (adds nothing), then read-only readbacks
        issue(1'b1, 8'd17, 2'b11, 1'b1, 8'd17, 1'b0, 8'd0);
        wait_idle();
        issue(1'b0, 8'd99, 2'b11, 1'b1, 8'd17, 1'b0, 8'd0);
        check_lat(1'b0, 8'd99, 2'b11);
        wait_idle();
        issue(1'b0, 8'd0, 2'b01, 1'b1, 8'd47, 1'b0, 8'd0);
        check_lat(1'b0, 8'd0, 2'b01);
        wait_idle();

        // Broken counter: reads 0 instead of 9, every request mismatches
        stuck = 1'b1;
        issue(1'b1, 8'd9, 2'b00, 1'b1, 8'd0, 1'b1, 8'd1);
        check_lat(1'b1, 8'd9, 2'b00);
        wait_idle();
        for (int i = 1; i < 300; i++) begin
            issue(1'b1, 8'd9, 2'b00, 1'b1, 8'd0, 1'b1,
                  (i + 1 > 255) ? 8'hFF : 8'(i + 1));
            wait_idle();
        end
        chk("errcount_sat", ErrCount, 8'hFF);
        stuck = 1'b0;

        // Consumer stall with a competing request that must be ignored
        RspReady = 1'b0;
        issue(1'b1, 8'd100, 2'b00, 1'b1, 8'd100, 1'b0, 8'hFF);
        check_lat(1'b1, 8'd100, 2'b00);
        ReqValid  = 1'b1;
        ReqWrite  = 1'b1;
        ReqVal    = 8'd7;
        ReqOffset = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("stall_rspvalid", 8'(RspValid), 8'd1);
            chk("stall_rspdata", RspData, 8'd100);
            chk("stall_reqready", 8'(ReqReady), 8'd0);
            chk("stall_wren", 8'(WriteEn), 8'd0);
        end
        @(posedge Clk);
        #1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqVal    = 8'h00;
        ReqOffset = 2'b00;
        RspReady  = 1'b1;
        wait_idle();

        // Reset in the middle of the READ cycle discards the transaction
        issue(1'b1, 8'd40, 2'b10, 1'b0, 8'd0, 1'b0, 8'd0);
        @(negedge Clk);
        chk("mid_wren", 8'(WriteEn), 8'd1);
        @(negedge Clk);
        chk("mid_ofs_read", 8'(Offset), 8'd2);
        Reset = 1'b0;
        #1;
        chk("mid_rst_rspvalid", 8'(RspValid), 8'd0);
        chk("mid_rst_wren", 8'(WriteEn), 8'd0);
        chk("mid_rst_errcount", ErrCount, 8'd0);
        chk("mid_rst_offset", 8'(Offset), 8'd0);
        chk("mid_rst_reqready", 8'(ReqReady), 8'd1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("post_rst_rspvalid", 8'(RspValid), 8'd0);
        end
        chk("post_rst_rspdata", RspData, 8'd0);
        @(posedge Clk);
        #1;

        // Recovery: counter cleared by reset, read code 01 gives 30
        issue(1'b0, 8'd0, 2'b01, 1'b1, 8'd30, 1'b0, 8'd0);
        check_lat(1'b0, 8'd0, 2'b01);
        wait_idle();

        repeat (3) @(negedge Clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
